// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
// Requester indices, register geometry and buffer state encoding.
package regfile_wb_arbiter_pkg;

  localparam int REG_W   = 32;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = $clog2(REG_NUM);

  localparam int WB_REQ0 = 0;
  localparam int WB_REQ1 = 1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_hold_buf.sv
// One-entry writeback holding slot with skid refill.
// Writes to x0 complete the handshake but are never stored.
module regfile_wb_arbiter_hold_buf
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW = REG_W,
  parameter int AW = REG_AW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_grant,
  output logic          o_ready,
  output logic          o_load,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  buf_state_e    r_state;
  buf_state_e    w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          w_fire;
  logic          w_store;

  assign w_fire  = i_valid & o_ready;
  assign w_store = w_fire & (i_addr != '0);

  // Slot occupancy register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Occupancy: a new accept wins over a drain on the same edge
  always_comb begin
    w_state_nxt = r_state;
    if (w_fire) begin
      w_state_nxt = w_store ? BUF_FULL : BUF_EMPTY;
    end else if (i_grant) begin
      w_state_nxt = BUF_EMPTY;
    end
  end

  // Payload capture only for entries that will be written
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_store) begin
      r_addr <= i_addr;
      r_data <= i_data;
    end
  end

  // Ready when empty or draining this cycle
  always_comb begin
    o_ready = (r_state == BUF_EMPTY) | i_grant;
    o_load  = w_store;
  end

  assign o_valid = (r_state == BUF_FULL);
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates EX and LSU writebacks onto the single regfile port.
// Also flags decode reads that hit a not-yet-written entry.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW = REG_W,
  parameter int AW = REG_AW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [1:0]    wb_valid_i,
  output logic [1:0]    wb_ready_o,
  input  logic [AW-1:0] wb_addr0_i,
  input  logic [DW-1:0] wb_data0_i,
  input  logic [AW-1:0] wb_addr1_i,
  input  logic [DW-1:0] wb_data1_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic          hz1_o,
  output logic          hz2_o
);

  logic          w_v0;
  logic          w_v1;
  logic [AW-1:0] w_a0;
  logic [AW-1:0] w_a1;
  logic [DW-1:0] w_d0;
  logic [DW-1:0] w_d1;
  logic          w_ld0;
  logic          w_ld1;
  logic          w_rdy0;
  logic          w_rdy1;
  logic [1:0]    w_gnt;
  logic          w_same;

  // Last grantee: 0 = req0, 1 = req1
  logic          r_rr;
  // Set when the req1 entry is older than req0
  logic          r_old1;

  regfile_wb_arbiter_hold_buf #(
    .DW(DW),
    .AW(AW)
  ) u_buf0 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_valid (wb_valid_i[WB_REQ0]),
    .i_addr  (wb_addr0_i),
    .i_data  (wb_data0_i),
    .i_grant (w_gnt[WB_REQ0]),
    .o_ready (w_rdy0),
    .o_load  (w_ld0),
    .o_valid (w_v0),
    .o_addr  (w_a0),
    .o_data  (w_d0)
  );

  regfile_wb_arbiter_hold_buf #(
    .DW(DW),
    .AW(AW)
  ) u_buf1 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_valid (wb_valid_i[WB_REQ1]),
    .i_addr  (wb_addr1_i),
    .i_data  (wb_data1_i),
    .i_grant (w_gnt[WB_REQ1]),
    .o_ready (w_rdy1),
    .o_load  (w_ld1),
    .o_valid (w_v1),
    .o_addr  (w_a1),
    .o_data  (w_d1)
  );

  assign wb_ready_o = {w_rdy1, w_rdy0};
  assign w_same     = (w_a0 == w_a1);

  // Grant: age decides same-address order, else round-robin
  always_comb begin
    w_gnt = 2'b00;
    unique case (1'b1)
      (w_v0 & w_v1): begin
        if (w_same) begin
          w_gnt = r_old1 ? 2'b10 : 2'b01;
        end else begin
          w_gnt = r_rr ? 2'b01 : 2'b10;
        end
      end
      (w_v0 & ~w_v1): w_gnt = 2'b01;
      (~w_v0 & w_v1): w_gnt = 2'b10;
      default:        w_gnt = 2'b00;
    endcase
  end

  // Round-robin pointer follows the grantee
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rr <= 1'b0;
    end else if (|w_gnt) begin
      r_rr <= w_gnt[WB_REQ1];
    end
  end

  // Age: the slot loaded alone is younger; same edge keeps req0 older
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_old1 <= 1'b0;
    end else if (w_ld0 & w_ld1) begin
      r_old1 <= 1'b0;
    end else if (w_ld0) begin
      r_old1 <= 1'b1;
    end else if (w_ld1) begin
      r_old1 <= 1'b0;
    end
  end

  // Regfile write port driven from the granted slot
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (w_gnt[WB_REQ0]) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = w_a0;
      rf_wdata_o = w_d0;
    end else if (w_gnt[WB_REQ1]) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = w_a1;
      rf_wdata_o = w_d1;
    end
  end

  // Hazards include the entry being written this cycle
  always_comb begin
    hz1_o = (raddr1_i != '0) &
            ((w_v0 & (w_a0 == raddr1_i)) |
             (w_v1 & (w_a1 == raddr1_i)));
    hz2_o = (raddr2_i != '0) &
            ((w_v0 & (w_a0 == raddr2_i)) |
             (w_v1 & (w_a1 == raddr2_i)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a
// slot/timestamp reference model and a shadow regfile.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_valid;
  logic [1:0]  wb_ready;
  logic [4:0]  a0, a1, ra1, ra2;
  logic [31:0] d0, d1;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hz1, hz2;

  int checks = 0;
  int errors = 0;

  // reference model: per-requester slot with load timestamp
  bit          mv[2];
  logic [4:0]  ma[2];
  logic [31:0] md[2];
  int          mseq[2];
  int          mlast;
  int          cyc;
  logic [31:0] mrf[32];
  logic [31:0] arf[32];

  int          e_g;
  logic [1:0]  e_ready;
  logic        e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  logic        e_hz1, e_hz2;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wb_valid_i (wb_valid),
    .wb_ready_o (wb_ready),
    .wb_addr0_i (a0),
    .wb_data0_i (d0),
    .wb_addr1_i (a1),
    .wb_data1_i (d1),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata),
    .raddr1_i   (ra1),
    .raddr2_i   (ra2),
    .hz1_o      (hz1),
    .hz2_o      (hz2)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic model_reset();
    mv[0] = 0;
    mv[1] = 0;
    mlast = 0;
  endtask

  task automatic model_eval();
    if (mv[0] && mv[1]) begin
      if (ma[0] == ma[1]) e_g = (mseq[1] < mseq[0]) ? 1 : 0;
      else e_g = 1 - mlast;
    end else if (mv[0]) e_g = 0;
    else if (mv[1]) e_g = 1;
    else e_g = -1;
    e_ready[0] = !mv[0] || (e_g == 0);
    e_ready[1] = !mv[1] || (e_g == 1);
    e_we    = (e_g >= 0);
    e_waddr = e_we ? ma[e_g] : 5'd0;
    e_wdata = e_we ? md[e_g] : 32'd0;
    e_hz1 = (ra1 != 0) &&
            ((mv[0] && ma[0] == ra1) || (mv[1] && ma[1] == ra1));
    e_hz2 = (ra2 != 0) &&
            ((mv[0] && ma[0] == ra2) || (mv[1] && ma[1] == ra2));
  endtask

  task automatic model_commit();
    if (e_g >= 0) begin
      mrf[ma[e_g]] = md[e_g];
      mv[e_g] = 0;
      mlast = e_g;
    end
    if (wb_valid[0] && e_ready[0]) begin
      mv[0] = (a0 != 0);
      ma[0] = a0;
      md[0] = d0;
      mseq[0] = cyc;
    end
    if (wb_valid[1] && e_ready[1]) begin
      mv[1] = (a1 != 0);
      ma[1] = a1;
      md[1] = d1;
      mseq[1] = cyc;
    end
    cyc++;
  endtask

  // apply inputs, evaluate model, log the DUT write at negedge
  task automatic drive(input logic [1:0] v,
                       input logic [4:0] x0, input logic [31:0] y0,
                       input logic [4:0] x1, input logic [31:0] y1,
                       input logic [4:0] r1, input logic [4:0] r2);
    wb_valid = v;
    a0 = x0; d0 = y0;
    a1 = x1; d1 = y1;
    ra1 = r1; ra2 = r2;
    @(negedge clk);
    model_eval();
    if (rf_we) arf[rf_waddr] = rf_wdata;
  endtask

  task automatic adv();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_valid = 2'b00;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    ra1 = 5'd5; ra2 = 5'd6;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2} !==
        {2'b11, 1'b0, 5'd0, 32'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_out: got rdy=%b we=%b a=%0d d=%h hz=%b%b exp 11 0 0 0 00",
               wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2);
    end
    rst_n = 1'b1;
    drive(2'b11, 5'd10, $urandom, 5'd11, $urandom, 5'd10, 5'd11);
    adv();
    wb_valid = 2'b00;
    #1;
    checks++;
    if ({hz1, hz2} !== 2'b11) begin
      errors++;
      $display("FAIL reset_prefull_hz: got %b%b exp 11", hz1, hz2);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2} !==
        {2'b11, 1'b0, 5'd0, 32'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b we=%b a=%0d d=%h hz=%b%b exp 11 0 0 0 00",
               wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 5'd10, 5'd11);
    checks++;
    if (rf_we !== 1'b0 || e_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_issue: got we=%b exp 0", rf_we);
    end
    adv();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (arf[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_rf x%0d: got %h exp 0", i, arf[i]);
      end
    end
  endtask

  task automatic test_single();
    drive(2'b01, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checks++;
    if (wb_ready !== 2'b11 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got rdy=%b we=%b exp 11 0", wb_ready, rf_we);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL single_write: got we=%b a=%0d d=%h exp 1 5 deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got we=%b exp 0", rf_we);
    end
    adv();
    checks++;
    if (arf[5] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_rf x5: got %h exp deadbeef", arf[5]);
    end
  endtask

  task automatic test_alternate();
    int prev;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 5'd3, $urandom, 5'd7, $urandom, 5'd3, 5'd7);
      checks++;
      if ({wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2} !==
          {e_ready, e_we, e_waddr, e_wdata, e_hz1, e_hz2}) begin
        errors++;
        $display("FAIL alt_out c%0d: got %b %b %0d %h %b%b exp %b %b %0d %h %b%b",
                 i, wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2,
                 e_ready, e_we, e_waddr, e_wdata, e_hz1, e_hz2);
      end
      if (i > 0) begin
        checks++;
        if (rf_we !== 1'b1 || int'(rf_waddr) == prev ||
            wb_ready == 2'b11) begin
          errors++;
          $display("FAIL alt_seq c%0d: got we=%b a=%0d prev=%0d rdy=%b",
                   i, rf_we, rf_waddr, prev, wb_ready);
        end
      end
      if (rf_we) prev = int'(rf_waddr);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {e_we, e_waddr, e_wdata}) begin
        errors++;
        $display("FAIL alt_drain: got %b %0d %h exp %b %0d %h",
                 rf_we, rf_waddr, rf_wdata, e_we, e_waddr, e_wdata);
      end
      adv();
    end
  endtask

  task automatic test_same_edge();
    drive(2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 0, 0);
    adv();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h11}) begin
      errors++;
      $display("FAIL same_first: got %b %0d %h exp 1 9 11", rf_we, rf_waddr, rf_wdata);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h22}) begin
      errors++;
      $display("FAIL same_second: got %b %0d %h exp 1 9 22", rf_we, rf_waddr, rf_wdata);
    end
    adv();
    checks++;
    if (arf[9] !== 32'h22) begin
      errors++;
      $display("FAIL same_final x9: got %h exp 22", arf[9]);
    end
    // req1 loaded first, then req0 to the same register
    drive(2'b11, 5'd20, $urandom, 5'd9, 32'h33, 0, 0);
    adv();
    drive(2'b01, 5'd9, 32'h44, 0, 0, 0, 0);
    checks++;
    if ({wb_ready[0], rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd20}) begin
      errors++;
      $display("FAIL rev_rr: got rdy0=%b we=%b a=%0d exp 1 1 20",
               wb_ready[0], rf_we, rf_waddr);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h33}) begin
      errors++;
      $display("FAIL rev_first: got %b %0d %h exp 1 9 33", rf_we, rf_waddr, rf_wdata);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h44}) begin
      errors++;
      $display("FAIL rev_second: got %b %0d %h exp 1 9 44", rf_we, rf_waddr, rf_wdata);
    end
    adv();
    checks++;
    if (arf[9] !== 32'h44) begin
      errors++;
      $display("FAIL rev_final x9: got %h exp 44", arf[9]);
    end
  endtask

  task automatic test_addr0();
    drive(2'b10, 0, 0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    checks++;
    if ({wb_ready[1], rf_we, hz1, hz2} !== 4'b1000) begin
      errors++;
      $display("FAIL addr0_accept: got rdy1=%b we=%b hz=%b%b exp 1 0 00",
               wb_ready[1], rf_we, hz1, hz2);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 5'd0, 5'd0);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, hz1, hz2} !== {1'b0, 5'd0, 32'd0, 2'b00}) begin
      errors++;
      $display("FAIL addr0_drop: got we=%b a=%0d d=%h hz=%b%b exp 0 0 0 00",
               rf_we, rf_waddr, rf_wdata, hz1, hz2);
    end
    adv();
  endtask

  task automatic test_hazard();
    drive(2'b01, 5'd12, $urandom, 0, 0, 5'd12, 5'd0);
    checks++;
    if ({hz1, hz2} !== 2'b00) begin
      errors++;
      $display("FAIL hz_before: got %b%b exp 00", hz1, hz2);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 5'd12, 5'd0);
    checks++;
    if ({hz1, hz2, rf_we, rf_waddr} !== {2'b10, 1'b1, 5'd12}) begin
      errors++;
      $display("FAIL hz_held: got hz=%b%b we=%b a=%0d exp 10 1 12",
               hz1, hz2, rf_we, rf_waddr);
    end
    adv();
    drive(2'b00, 0, 0, 0, 0, 5'd12, 5'd0);
    checks++;
    if ({hz1, hz2} !== 2'b00) begin
      errors++;
      $display("FAIL hz_after: got %b%b exp 00", hz1, hz2);
    end
    adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      checks++;
      if ({wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2} !==
          {e_ready, e_we, e_waddr, e_wdata, e_hz1, e_hz2}) begin
        errors++;
        $display("FAIL rand c%0d: got %b %b %0d %h %b%b exp %b %b %0d %h %b%b",
                 i, wb_ready, rf_we, rf_waddr, rf_wdata, hz1, hz2,
                 e_ready, e_we, e_waddr, e_wdata, e_hz1, e_hz2);
      end
      adv();
    end
    repeat (3) begin
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      adv();
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (arf[i] !== mrf[i]) begin
        errors++;
        $display("FAIL rand_rf x%0d: got %h exp %h", i, arf[i], mrf[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mrf[i] = 32'd0;
      arf[i] = 32'd0;
    end
    cyc = 0;
    mseq[0] = 0;
    mseq[1] = 0;
    test_reset();
    test_single();
    test_alternate();
    test_same_edge();
    test_addr0();
    test_hazard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
